// File: rtl/vit_traceback_pkg.sv
// ============================================================================
//  Module      : vit_traceback_pkg
//  Description : Shared constants, FSM encoding and trellis helper for the
//                Viterbi survivor-memory / traceback stage.
//                Optional build macro: VIT_TB_BEST_STATE_EN (used by the top).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package vit_traceback_pkg;

    localparam int NUM_STATES = 64;
    localparam int STATE_W    = 6;

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        TRACE  = 3'd1,
        DECODE = 3'd2,
        OUTPUT = 3'd3,
        FLUSH  = 3'd4
    } tb_fsm_e;

    // Input bits enter the state at the MSB, so the predecessor shifts left
    // and takes the survivor bit as its new LSB.
    function automatic logic [STATE_W-1:0] pred_state(
        input logic [STATE_W-1:0] state,
        input logic               sur_bit
    );
        return {state[STATE_W-2:0], sur_bit};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vit_tb_lifo.sv
// ============================================================================
//  Module      : vit_tb_lifo
//  Description : Bit-wide push/pop stack that reverses traceback order into
//                chronological order. Top-of-stack is read combinationally.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vit_tb_lifo
    import vit_traceback_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             din_i,
    output logic             dout_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int               ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  mem_q;
    logic [CNT_W-1:0]  sp_q;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] top_idx;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_i && (sp_q != FULL);
    assign do_pop  = pop_i && !push_i && (sp_q != '0);
    assign wr_idx  = ADDR_W'(sp_q);
    assign top_idx = ADDR_W'(sp_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (do_push) begin
            sp_q <= sp_q + 1'b1;
        end else if (do_pop) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din_i;
        end
    end

    assign dout_o = mem_q[top_idx];
    assign cnt_o  = sp_q;

endmodule

`default_nettype wire

// File: rtl/vit_traceback.sv
// ============================================================================
//  Module      : vit_traceback
//  Description : Viterbi survivor ring buffer with block traceback and
//                chronological bit output. Build macro VIT_TB_BEST_STATE_EN
//                selects the steady-state traceback start state.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vit_traceback
    import vit_traceback_pkg::*;
#(
    parameter int TB_DEPTH  = 32,
    parameter int DEC_LEN   = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  di_vld,
    input  logic [NUM_STATES-1:0] di_sur,
    input  logic [STATE_W-1:0]    di_best_state,
    input  logic                  di_last,
    output logic                  do_in_rdy,
    output logic                  do_bit,
    output logic                  do_vld,
    output logic                  do_last
);

    localparam int               PTR_W    = $clog2(MEM_DEPTH);
    localparam int               CNT_W    = $clog2(MEM_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] TB_LAST  = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(DEC_LEN - 1);
    localparam logic [CNT_W-1:0] DEC_CNT  = CNT_W'(DEC_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tb_fsm_e               state_q;
    logic [NUM_STATES-1:0] mem_q [MEM_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      step_q;
    logic [STATE_W-1:0]    tb_state_q;
    logic [STATE_W-1:0]    tb_state_d;
    logic [STATE_W-1:0]    start_state;
    logic                  flush_q;
    logic                  do_in_rdy_q;
    logic                  do_vld_q;
    logic                  do_bit_q;
    logic                  do_last_q;
    logic                  accept;
    logic [NUM_STATES-1:0] sur_vec;
    logic                  lifo_push;
    logic                  lifo_pop;
    logic                  lifo_dout;
    logic [CNT_W-1:0]      lifo_cnt;

`ifdef VIT_TB_BEST_STATE_EN
    assign start_state = di_best_state;
`else
    logic unused_best_state;
    assign unused_best_state = ^di_best_state;
    assign start_state       = '0;
`endif

    assign accept     = di_vld && do_in_rdy_q;
    assign wr_ptr_d   = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_d   = (rd_ptr_q == '0) ? PTR_LAST : rd_ptr_q - 1'b1;
    assign sur_vec    = mem_q[rd_ptr_q];
    assign tb_state_d = pred_state(tb_state_q, sur_vec[tb_state_q]);
    assign lifo_push  = (state_q == DECODE) || (state_q == FLUSH);
    assign lifo_pop   = (state_q == OUTPUT);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= di_sur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            step_q      <= '0;
            tb_state_q  <= '0;
            flush_q     <= 1'b0;
            do_in_rdy_q <= 1'b0;
            do_vld_q    <= 1'b0;
            do_bit_q    <= 1'b0;
            do_last_q   <= 1'b0;
        end else begin
            do_vld_q  <= 1'b0;
            do_bit_q  <= 1'b0;
            do_last_q <= 1'b0;
            case (state_q)
                FILL: begin
                    do_in_rdy_q <= 1'b1;
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_d;
                        rd_ptr_q <= wr_ptr_q;
                        cnt_q    <= cnt_q + 1'b1;
                        step_q   <= '0;
                        // di_last wins over a full buffer: the frame ends here.
                        if (di_last) begin
                            state_q     <= FLUSH;
                            tb_state_q  <= '0;
                            flush_q     <= 1'b1;
                            do_in_rdy_q <= 1'b0;
                        end else if (cnt_q == CNT_PRE) begin
                            state_q     <= TRACE;
                            tb_state_q  <= start_state;
                            flush_q     <= 1'b0;
                            do_in_rdy_q <= 1'b0;
                        end
                    end
                end
                TRACE: begin
                    tb_state_q <= tb_state_d;
                    rd_ptr_q   <= rd_ptr_d;
                    if (step_q == TB_LAST) begin
                        state_q <= DECODE;
                        step_q  <= '0;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DECODE: begin
                    tb_state_q <= tb_state_d;
                    rd_ptr_q   <= rd_ptr_d;
                    if (step_q == DEC_LAST) begin
                        state_q <= OUTPUT;
                        step_q  <= '0;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                FLUSH: begin
                    tb_state_q <= tb_state_d;
                    rd_ptr_q   <= rd_ptr_d;
                    if (step_q == cnt_q - 1'b1) begin
                        state_q <= OUTPUT;
                        step_q  <= '0;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                OUTPUT: begin
                    do_vld_q <= 1'b1;
                    do_bit_q <= lifo_dout;
                    if (lifo_cnt == CNT_ONE) begin
                        state_q     <= FILL;
                        do_in_rdy_q <= 1'b1;
                        if (flush_q) begin
                            do_last_q <= 1'b1;
                            cnt_q     <= '0;
                            wr_ptr_q  <= '0;
                            rd_ptr_q  <= '0;
                            flush_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - DEC_CNT;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    vit_tb_lifo #(
        .DEPTH (MEM_DEPTH),
        .CNT_W (CNT_W)
    ) u_lifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (lifo_push),
        .pop_i  (lifo_pop),
        .din_i  (tb_state_q[STATE_W-1]),
        .dout_o (lifo_dout),
        .cnt_o  (lifo_cnt)
    );

    assign do_in_rdy = do_in_rdy_q;
    assign do_vld    = do_vld_q;
    assign do_bit    = do_bit_q;
    assign do_last   = do_last_q;

endmodule

`default_nettype wire
